// File: rtl/divider_pkg.sv
// Shared definitions for the sequential unsigned restoring divider.
//   state_t  : controller states
//   DEF_N/M  : default dividend/divisor widths
//   cnt_w()  : iteration counter width for a given dividend width
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_N = 8;
  localparam int DEF_M = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/unsigned_divider_if.sv
// Start/done handshake bundle for unsigned_divider.
//   master : drives start, A (dividend), B (divisor)
//   slave  : returns busy, done, Q (quotient), R (remainder), div_by_zero
interface unsigned_divider_if
  import divider_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) ();
  logic         start;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         div_by_zero;

  modport master (output start, A, B, input busy, done, Q, R, div_by_zero);
  modport slave  (input start, A, B, output busy, done, Q, R, div_by_zero);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   i_rem  : partial remainder (M+1 bits, always < divisor)
//   i_msb  : dividend bit shifted in
//   i_dvs  : divisor
//   o_rem  : next partial remainder
//   o_qbit : quotient bit produced by this step
module div_step #(
  parameter int M = 4
) (
  input  logic [M:0]   i_rem,
  input  logic         i_msb,
  input  logic [M-1:0] i_dvs,
  output logic [M:0]   o_rem,
  output logic         o_qbit
);
  logic [M+1:0] w_shift;
  logic [M+1:0] w_diff;

  // One guard bit above the remainder so the sign of the trial
  // subtraction is visible without losing the shifted-in value.
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  assign o_qbit  = ~w_diff[M+1];
  assign o_rem   = o_qbit ? w_diff[M:0] : w_shift[M:0];
endmodule

// File: rtl/unsigned_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of unsigned_divider_if (start/A/B in,
//         busy/done/Q/R/div_by_zero out, all outputs registered)
module unsigned_divider
  import divider_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic               clk,
  input  logic               rst,
  unsigned_divider_if.slave  bus
);
  localparam int CW = cnt_w(N);

  state_t        r_state;
  logic [M:0]    r_rem;
  logic [N-1:0]  r_dvd;
  logic [M-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_zpend;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_q;
  logic [M-1:0]  r_r;
  logic          r_dbz;

  logic [M:0]    w_rem_nxt;
  logic          w_qbit;
  logic [N-1:0]  w_dvd_nxt;

  div_step #(.M(M)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_dvd[N-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Dividend register doubles as the quotient register: bits shift out
  // the top into the remainder while quotient bits fill from the bottom.
  assign w_dvd_nxt = {r_dvd[N-2:0], w_qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_zpend <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dvd_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= w_dvd_nxt;
            r_r     <= w_rem_nxt[M-1:0];
            r_dbz   <= 1'b0;
          end
        end
        IDLE, DONE: begin
          if (r_state == DONE && r_zpend) begin
            // Zero divisor: the DONE state is entered on the accepting edge
            // but the done pulse is deferred one cycle, giving latency 1.
            r_zpend <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= '1;
            r_r     <= r_dvd[M-1:0];
            r_dbz   <= 1'b1;
          end else if (bus.start) begin
            r_dvd <= bus.A;
            r_dvs <= bus.B;
            r_rem <= '0;
            r_cnt <= CW'(N - 1);
            if (bus.B == '0) begin
              r_state <= DONE;
              r_zpend <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.div_by_zero = r_dbz;
endmodule
